// File: rtl/rr_arb8_pkg.sv
`default_nettype none
// ============================================================================
// Module  : rr_arb8_pkg
// Brief   : Shared constants and FSM state encoding for the rr_arb8 arbiter.
// Rev     : 1.0  initial release
// ============================================================================
package rr_arb8_pkg;

    localparam int c_n_req       = 8;
    localparam int c_idx_w       = 3;
    localparam int c_timeout_def = 16;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

endpackage : rr_arb8_pkg
`default_nettype wire

// File: rtl/rr_arb8_if.sv
`default_nettype none
// ============================================================================
// Module  : rr_arb8_if
// Brief   : Request/grant bundle between requesters (master) and rr_arb8 (slave).
// Rev     : 1.0  initial release
// ============================================================================
interface rr_arb8_if;
    import rr_arb8_pkg::*;

    logic                 EN;
    logic [c_n_req-1:0]   req;
    logic                 done;
    logic [c_n_req-1:0]   gnt;
    logic [c_idx_w-1:0]   gnt_id;
    logic                 valid;
    logic                 timeout;

    modport master (
        output EN, req, done,
        input  gnt, gnt_id, valid, timeout
    );

    modport slave (
        input  EN, req, done,
        output gnt, gnt_id, valid, timeout
    );

endinterface : rr_arb8_if
`default_nettype wire

// File: rtl/rr_arb8_grant_enc.sv
`default_nettype none
// ============================================================================
// Module  : grant_enc
// Brief   : One-hot to binary index encoder; an all-zero input encodes to 0.
// Rev     : 1.0  initial release
// ============================================================================
module grant_enc
    import rr_arb8_pkg::*;
(
    input  wire logic [c_n_req-1:0] i_onehot,
    output logic      [c_idx_w-1:0] o_idx
);

    // OR-ing the indices of set bits keeps zero input at zero with no priority chain.
    always_comb begin
        o_idx = '0;
        for (int i = 0; i < c_n_req; i++) begin
            if (i_onehot[i]) begin
                o_idx = o_idx | c_idx_w'(i);
            end
        end
    end

endmodule : grant_enc
`default_nettype wire

// File: rtl/rr_arb8.sv
`default_nettype none
// ============================================================================
// Module  : rr_arb8
// Brief   : 8-way round-robin arbiter with registered one-hot grant and
//           owner release; optional grant-hold timeout under ARB_TIMEOUT_EN.
// Rev     : 1.0  initial release
// ============================================================================
module rr_arb8
    import rr_arb8_pkg::*;
#(
    parameter int TIMEOUT = c_timeout_def
)
(
    input  wire logic clk,
    input  wire logic rst,
    rr_arb8_if.slave  bus
);

    if ((TIMEOUT < 2) || (TIMEOUT > 255)) begin : g_timeout_range
        $error("rr_arb8: TIMEOUT must lie in 2..255");
    end

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_n_req-1:0]   r_gnt;
    logic [c_n_req-1:0]   w_gnt_nxt;
    logic [c_idx_w-1:0]   r_ptr;
    logic [c_idx_w-1:0]   w_ptr_nxt;
    logic [c_idx_w-1:0]   w_owner;
    logic [c_n_req-1:0]   w_req_rot;
    logic [c_n_req-1:0]   w_pick_rot;
    logic [c_n_req-1:0]   w_pick;
    logic                 w_release;

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] c_limit = 8'(TIMEOUT);

    logic [7:0]           r_cnt;
    logic [7:0]           w_cnt_nxt;
    logic                 r_timeout;
    logic                 w_timeout_nxt;
`endif

    grant_enc u_grant_enc (
        .i_onehot (r_gnt),
        .o_idx    (w_owner)
    );

    // Rotate so ptr lands at bit 0, keep the lowest set bit, rotate back.
    always_comb begin
        w_req_rot = '0;
        w_pick    = '0;
        for (int i = 0; i < c_n_req; i++) begin
            w_req_rot[i] = bus.req[c_idx_w'(i) + r_ptr];
        end
        w_pick_rot = w_req_rot & (~w_req_rot + 8'd1);
        for (int i = 0; i < c_n_req; i++) begin
            w_pick[c_idx_w'(i) + r_ptr] = w_pick_rot[i];
        end
    end

    assign w_release = bus.done | ~bus.req[w_owner];

    always_comb begin
        w_state_nxt   = r_state;
        w_gnt_nxt     = r_gnt;
        w_ptr_nxt     = r_ptr;
`ifdef ARB_TIMEOUT_EN
        w_cnt_nxt     = r_cnt;
        w_timeout_nxt = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (bus.EN && (bus.req != '0)) begin
                    w_state_nxt = ST_GRANT;
                    w_gnt_nxt   = w_pick;
`ifdef ARB_TIMEOUT_EN
                    w_cnt_nxt   = 8'd1;
`endif
                end
            end
            ST_GRANT: begin
                // A normal release wins over a coincident timeout.
                if (w_release) begin
                    w_state_nxt   = ST_IDLE;
                    w_gnt_nxt     = '0;
                    w_ptr_nxt     = w_owner + 3'd1;
`ifdef ARB_TIMEOUT_EN
                    w_cnt_nxt     = 8'd0;
                end else if (r_cnt == c_limit) begin
                    w_state_nxt   = ST_IDLE;
                    w_gnt_nxt     = '0;
                    w_ptr_nxt     = w_owner + 3'd1;
                    w_cnt_nxt     = 8'd0;
                    w_timeout_nxt = 1'b1;
                end else begin
                    w_cnt_nxt     = r_cnt + 8'd1;
`endif
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_gnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_gnt     <= '0;
            r_ptr     <= '0;
`ifdef ARB_TIMEOUT_EN
            r_cnt     <= 8'd0;
            r_timeout <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_gnt     <= w_gnt_nxt;
            r_ptr     <= w_ptr_nxt;
`ifdef ARB_TIMEOUT_EN
            r_cnt     <= w_cnt_nxt;
            r_timeout <= w_timeout_nxt;
`endif
        end
    end

    assign bus.gnt    = r_gnt;
    assign bus.gnt_id = w_owner;
    assign bus.valid  = (r_gnt != '0);
`ifdef ARB_TIMEOUT_EN
    assign bus.timeout = r_timeout;
`else
    assign bus.timeout = 1'b0;
`endif

endmodule : rr_arb8
`default_nettype wire
